// File: rtl/c499_enc_pipe.sv
// c499_enc_pipe: two-stage valid/ready encoder that produces the 32 data bits
// and 8 check bits feeding a c499 single-error-correcting decoder, with an
// optional single-bit error injected on the way out.
//
// Stage 1 captures the data word plus its eight nibble parities and eight
// column parities. Stage 2 folds those partial parities into the final check
// bits and applies the injection mask. Each stage holds its word until the
// stage after it can take it, so throughput is one word per clock while the
// consumer is ready.
module c499_enc_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        inj_en,
   input  logic [5:0]  inj_pos,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_check,
   output logic        out_en,
   output logic [15:0] word_cnt
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic        en_q;          // low in reset, high from the first edge after
   logic        s1_vld_q;
   logic        s2_vld_q;
   logic [31:0] s1_data_q;
   logic [7:0]  s1_npar_q;     // nibble parity X(d[4k+3:4k])
   logic [7:0]  s1_cpar_q;     // [3:0] low-half columns, [7:4] high-half columns
   logic        s1_inj_q;
   logic [5:0]  s1_pos_q;
   logic [31:0] s2_data_q;
   logic [7:0]  s2_chk_q;
   logic [15:0] cnt_q;

   // ---------------------------------------------------------------------
   // Handshake control
   // ---------------------------------------------------------------------
   logic s2_load;
   logic s1_load;
   logic in_fire;
   logic out_fire;

   assign s2_load  = ~s2_vld_q | out_ready;
   assign s1_load  = ~s1_vld_q | s2_load;
   // en_q keeps in_ready low during reset even though both stages are empty.
   assign in_ready = en_q & s1_load;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = s2_vld_q & out_ready;

   // ---------------------------------------------------------------------
   // Stage 1 combinational: partial parities of the incoming word
   // ---------------------------------------------------------------------
   logic [7:0] npar_d;
   logic [7:0] cpar_d;

   // Nibble parities and the per-half column parities (bits j, j+4, j+8, j+12).
   always_comb begin
      npar_d = '0;
      cpar_d = '0;
      for (int k = 0; k < 8; k++) begin
         npar_d[k] = ^in_data[4*k +: 4];
      end
      for (int j = 0; j < 4; j++) begin
         cpar_d[j]   = in_data[j]    ^ in_data[j+4]  ^ in_data[j+8]  ^ in_data[j+12];
         cpar_d[4+j] = in_data[16+j] ^ in_data[20+j] ^ in_data[24+j] ^ in_data[28+j];
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 combinational: check bits and injection masks
   // ---------------------------------------------------------------------
   logic [7:0]  chk_d;
   logic [31:0] dmask_d;
   logic [7:0]  cmask_d;

   // Each check bit is one column parity of one half combined with two
   // nibble parities of the other half. The check bits are always built from
   // the clean word so that a data-bit injection shows up as a single error.
   always_comb begin
      chk_d    = '0;
      chk_d[0] = s1_cpar_q[0] ^ s1_npar_q[4] ^ s1_npar_q[5];
      chk_d[1] = s1_cpar_q[1] ^ s1_npar_q[6] ^ s1_npar_q[7];
      chk_d[2] = s1_cpar_q[2] ^ s1_npar_q[4] ^ s1_npar_q[6];
      chk_d[3] = s1_cpar_q[3] ^ s1_npar_q[5] ^ s1_npar_q[7];
      chk_d[4] = s1_cpar_q[4] ^ s1_npar_q[0] ^ s1_npar_q[1];
      chk_d[5] = s1_cpar_q[5] ^ s1_npar_q[2] ^ s1_npar_q[3];
      chk_d[6] = s1_cpar_q[6] ^ s1_npar_q[0] ^ s1_npar_q[2];
      chk_d[7] = s1_cpar_q[7] ^ s1_npar_q[1] ^ s1_npar_q[3];
   end

   // Positions 0-31 hit a data bit, 32-39 a check bit, 40-63 nothing.
   always_comb begin
      dmask_d = '0;
      cmask_d = '0;
      if (s1_inj_q) begin
         if (s1_pos_q[5] == 1'b0) begin
            dmask_d = 32'h1 << s1_pos_q[4:0];
         end else if (s1_pos_q[4:3] == 2'b00) begin
            cmask_d = 8'h1 << s1_pos_q[2:0];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Sequential
   // ---------------------------------------------------------------------

   // Output enable: forced low in reset, high from the first clock edge after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) en_q <= 1'b0;
      else     en_q <= 1'b1;
   end

   // Stage 1: valid follows an accepted input whenever the stage may load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_npar_q <= '0;
         s1_cpar_q <= '0;
         s1_inj_q  <= 1'b0;
         s1_pos_q  <= '0;
      end else begin
         if (s1_load) s1_vld_q <= in_fire;
         // Payload only moves on a real handshake, so idle inputs are ignored.
         if (in_fire) begin
            s1_data_q <= in_data;
            s1_npar_q <= npar_d;
            s1_cpar_q <= cpar_d;
            s1_inj_q  <= inj_en;
            s1_pos_q  <= inj_pos;
         end
      end
   end

   // Stage 2: takes stage 1 when empty or drained; holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_chk_q  <= '0;
      end else if (s2_load) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_data_q <= s1_data_q ^ dmask_d;
            s2_chk_q  <= chk_d ^ cmask_d;
         end
      end
   end

   // Completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cnt_q <= '0;
      else if (out_fire) cnt_q <= cnt_q + 16'd1;
   end

   assign out_valid = s2_vld_q;
   assign out_data  = s2_data_q;
   assign out_check = s2_chk_q;
   assign out_en    = en_q;
   assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_c499_enc_pipe.sv
// Randomized and directed bench for c499_enc_pipe. The reference encodes each
// check bit as the XOR of the data bits selected by a mask, and the decoder
// model corrects one data bit by matching the syndrome against single-bit
// encodings.
module tb_c499_enc_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        inj_en = 1'b0;
   logic [5:0]  inj_pos = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [7:0]  out_check;
   logic        out_en;
   logic [15:0] word_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  chk;
      logic [31:0] orig;
   } exp_t;

   c499_enc_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .inj_en(inj_en), .inj_pos(inj_pos),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_check(out_check),
      .out_en(out_en), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // Data bits covered by each check bit.
   logic [31:0] cmask [8] = '{32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
                              32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0};

   function automatic logic [7:0] ref_check(input logic [31:0] d);
      logic [7:0] c;
      for (int k = 0; k < 8; k++) c[k] = ^(d & cmask[k]);
      return c;
   endfunction

   function automatic exp_t make_exp(input logic [31:0] d, input logic en, input logic [5:0] pos);
      exp_t e;
      e.orig = d;
      e.data = d;
      e.chk  = ref_check(d);
      if (en && pos < 32)                e.data[pos] = ~e.data[pos];
      else if (en && pos >= 32 && pos < 40) e.chk[pos-32] = ~e.chk[pos-32];
      return e;
   endfunction

   // Single-error-correcting decode: syndrome matching one data bit's
   // signature flips that bit; check-bit errors leave the data untouched.
   function automatic logic [31:0] decode(input logic [31:0] d, input logic [7:0] c);
      logic [7:0]  s;
      logic [31:0] r;
      s = ref_check(d) ^ c;
      r = d;
      for (int i = 0; i < 32; i++)
         if (s != 8'h00 && s == ref_check(32'h1 << i)) r[i] = ~r[i];
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 ||
          out_check !== 8'h0 || out_en !== 1'b0 || word_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: got v=%b r=%b d=%h c=%h en=%b cnt=%h expected all zero",
                  out_valid, in_ready, out_data, out_check, out_en, word_cnt);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_en=%b expected 1 1", in_ready, out_en);
      end
   endtask

   task automatic test_directed();
      logic [31:0] td [7] = '{32'h0, 32'h1, 32'h00010000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
      logic        te [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [5:0]  tp [7] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd33, 6'd5, 6'd45};
      logic [31:0] xd [7] = '{32'h0, 32'h1, 32'h00010000, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h0};
      logic [7:0]  xc [7] = '{8'h00, 8'h51, 8'h15, 8'h00, 8'h02, 8'h00, 8'h00};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = td[i]; inj_en = te[i]; inj_pos = tp[i];
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL dir_ready[%0d]: got %b expected 1", i, in_ready);
         end
         @(posedge clk); #1;
         in_valid = 1'b0; in_data = $urandom; inj_en = 1'b1; inj_pos = $urandom_range(31);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL dir_latency[%0d]: out_valid got %b expected 0", i, out_valid);
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== xd[i] || out_check !== xc[i]) begin
            errors++;
            $display("FAIL dir_word[%0d]: got v=%b d=%h c=%h expected v=1 d=%h c=%h",
                     i, out_valid, out_data, out_check, xd[i], xc[i]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (word_cnt !== 16'd7 || out_valid !== 1'b0) begin
         errors++; $display("FAIL dir_count: got cnt=%0d v=%b expected 7 0", word_cnt, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      int sent = 0, got = 0, cyc = 0;
      logic hold = 1'b0, saw_low = 1'b0;
      logic [31:0] pd = '0;
      logic [7:0]  pc = '0;
      do_reset();
      while (got < 4 && cyc < 40) begin
         cyc++;
         in_valid  = (sent < 4);
         in_data   = $urandom;
         inj_en    = 1'b0;
         out_ready = !(cyc >= 3 && cyc <= 6);
         @(negedge clk);
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd || out_check !== pc) begin
               errors++;
               $display("FAIL b2b_hold: got v=%b d=%h c=%h expected v=1 d=%h c=%h",
                        out_valid, out_data, out_check, pd, pc);
            end
         end
         hold = out_valid && !out_ready; pd = out_data; pc = out_check;
         if (in_valid && !in_ready) saw_low = 1'b1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_spurious: got d=%h expected no word", out_data);
            end else begin
               e = q.pop_front();
               if (out_data !== e.data || out_check !== e.chk) begin
                  errors++;
                  $display("FAIL b2b_word: got d=%h c=%h expected d=%h c=%h",
                           out_data, out_check, e.data, e.chk);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(make_exp(in_data, 1'b0, 6'd0)); sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 4 || word_cnt !== 16'd4 || !saw_low) begin
         errors++;
         $display("FAIL b2b_summary: got words=%0d cnt=%0d ready_fell=%b expected 4 4 1",
                  got, word_cnt, saw_low);
      end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int sent = 0, got = 0, cyc = 0;
      logic hold = 1'b0;
      logic [31:0] pd = '0;
      logic [7:0]  pc = '0;
      do_reset();
      while (got < 1000 && cyc < 20000) begin
         cyc++;
         in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
         in_data   = $urandom;
         inj_en    = ($urandom_range(9) < 3);
         inj_pos   = 6'($urandom_range(63));
         out_ready = ($urandom_range(3) != 0);
         @(negedge clk);
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd || out_check !== pc) begin
               errors++;
               $display("FAIL rnd_hold: got v=%b d=%h c=%h expected v=1 d=%h c=%h",
                        out_valid, out_data, out_check, pd, pc);
            end
         end
         hold = out_valid && !out_ready; pd = out_data; pc = out_check;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rnd_spurious: got d=%h expected no word", out_data);
            end else begin
               e = q.pop_front();
               if (out_data !== e.data || out_check !== e.chk) begin
                  errors++;
                  $display("FAIL rnd_word[%0d]: got d=%h c=%h expected d=%h c=%h",
                           got, out_data, out_check, e.data, e.chk);
               end
               checks++;
               if (decode(out_data, out_check) !== e.orig) begin
                  errors++;
                  $display("FAIL rnd_decode[%0d]: got %h expected %h",
                           got, decode(out_data, out_check), e.orig);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(make_exp(in_data, inj_en, inj_pos)); sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (got != 1000 || word_cnt !== 16'd1000) begin
         errors++;
         $display("FAIL rnd_summary: got words=%0d cnt=%0d expected 1000 1000", got, word_cnt);
      end
   endtask

   task automatic test_reset_midflight();
      int stale = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inj_en    = 1'b0;
      repeat (2) begin
         in_data = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || word_cnt !== 16'd1000) begin
         errors++;
         $display("FAIL mid_setup: got v=%b cnt=%0d expected 1 1000", out_valid, word_cnt);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || word_cnt !== 16'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b cnt=%0d r=%b expected 0 0 0",
                  out_valid, word_cnt, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0 || word_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_stale: got stale=%0d cnt=%0d expected 0 0", stale, word_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
